press_grouper: RTL and testbench
================================

PRESS_GROUPER -- requirements
Module: press_grouper

Interface
REQ-001 The block SHALL have parameter GAP, default 16, meaning the number of idle cycles after an event that closes a group (legal range 2..255).
REQ-002 The block SHALL have parameter MAX, default 7, meaning the saturation limit of the group event count (legal range 1..7).
REQ-003 Port clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port evt  input  1  single-cycle event pulse from the upstream long-press detector, synchronous to clk.
REQ-006 Port ready  input  1  downstream consumer accepts the current group.
REQ-007 Port valid  output  1  a closed group is presented; registered.
REQ-008 Port count  output  3  number of events in the presented group, 1..MAX; registered.
REQ-009 Port overflow  output  1  the presented group contained more than MAX events; registered.
REQ-010 Port lost  output  1  sticky flag: at least one event was discarded; registered.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, COLLECT and HOLD.
REQ-012 IDLE, evt=1: next state COLLECT; count=1; overflow=0; timer=0.
REQ-013 IDLE, evt=0: remain in IDLE; count and overflow unchanged.
REQ-014 COLLECT, evt=1, count<MAX: count increments by 1; timer resets to 0.
REQ-015 COLLECT, evt=1, count==MAX: count holds at MAX; overflow set to 1; timer resets to 0.
REQ-016 COLLECT, evt=0, timer<GAP-1: timer increments by 1.
REQ-017 COLLECT, evt=0, timer==GAP-1: next state HOLD; valid=1 from the next cycle. valid therefore rises exactly GAP+1 cycles after the clock cycle of the last event.
REQ-018 COLLECT, evt=1 in the same cycle as timer==GAP-1: the event wins; count updates per REQ-014/015 and the state stays COLLECT.
REQ-019 HOLD: count and overflow SHALL stay stable while valid=1.
REQ-020 HOLD, valid=1 and ready=1 (handshake) with evt=0: next state IDLE; valid=0 next cycle.
REQ-021 HOLD, handshake with evt=1 in the same cycle: next state COLLECT; count=1; overflow=0; timer=0; valid=0 next cycle.
REQ-022 HOLD, evt=1 without handshake: the event is discarded; lost set to 1.
REQ-023 Once set, lost SHALL remain 1 until reset.
REQ-024 The timer SHALL be wide enough to hold GAP-1 and SHALL never wrap.
REQ-025 ready while valid=0 SHALL have no effect.
REQ-026 Outputs SHALL have no combinational path from any input.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, valid=0, count=0, overflow=0, lost=0 and timer=0, regardless of clk.
REQ-028 Reset asserted mid-group or during HOLD SHALL discard the group; no valid pulse SHALL follow deassertion.
REQ-029 An evt in the first clock edge after rst_n deasserts SHALL be processed per REQ-012.

Verification (GAP=4, MAX=3)
REQ-030 Single event: evt at cycle 10 -> valid=1 from cycle 15, count=1, overflow=0; ready=1 at cycle 17 -> valid=0 at cycle 18.
REQ-031 Grouping: evt at cycles 10, 13 and 17 -> one group; valid=1 from cycle 22, count=3, overflow=0.
REQ-032 Saturation: evt at cycles 10, 11, 12, 13 and 14 -> valid=1 from cycle 19, count=3, overflow=1.
REQ-033 Boundary: evt at cycle 10 and again at cycle 14 (the timer==GAP-1 cycle) -> same group; count=2; valid=1 from cycle 19.
REQ-034 HOLD events: group presented, ready=0, evt pulses -> lost=1, count unchanged. evt coincident with handshake -> a new group with count=1, presented GAP+1 cycles later.
REQ-035 Reset during COLLECT: evt at cycle 10, rst_n=0 at cycle 12 -> all outputs 0 and valid never asserts for that group.

Source files
------------

// File: rtl/press_grouper.sv
// Groups long-press events separated by less than GAP idle cycles into one
// counted group and presents it downstream over a valid/ready handshake.
module press_grouper #(
  parameter int unsigned GAP = 16,
  parameter int unsigned MAX = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       evt,
  input  logic       ready,
  output logic       valid,
  output logic [2:0] count,
  output logic       overflow,
  output logic       lost
);

  localparam int unsigned TW = $clog2(GAP);
  localparam logic [TW-1:0] TLAST = TW'(GAP - 1);
  localparam logic [2:0] CMAX = 3'(MAX);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t r_state;
  state_t w_state;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer;
  logic [2:0] r_count;
  logic [2:0] w_count;
  logic r_ovf;
  logic w_ovf;
  logic r_lost;
  logic w_lost;
  logic r_valid;
  logic w_valid;
  logic w_hs;

  assign w_hs = r_valid & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_lost  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state;
      r_timer <= w_timer;
      r_count <= w_count;
      r_ovf   <= w_ovf;
      r_lost  <= w_lost;
      r_valid <= w_valid;
    end
  end

  always_comb begin
    w_state = r_state;
    w_timer = r_timer;
    w_count = r_count;
    w_ovf   = r_ovf;
    w_lost  = r_lost;
    w_valid = r_valid;
    unique case (r_state)
      IDLE: begin
        if (evt) begin
          w_state = COLLECT;
          w_count = 3'd1;
          w_ovf   = 1'b0;
          w_timer = '0;
        end
      end
      COLLECT: begin
        // an event on the last idle cycle still extends the group
        if (evt) begin
          w_timer = '0;
          if (r_count < CMAX) begin
            w_count = r_count + 3'd1;
          end else begin
            w_ovf = 1'b1;
          end
        end else if (r_timer == TLAST) begin
          w_state = HOLD;
          w_valid = 1'b1;
        end else begin
          w_timer = r_timer + 1'b1;
        end
      end
      HOLD: begin
        if (w_hs) begin
          w_valid = 1'b0;
          if (evt) begin
            w_state = COLLECT;
            w_count = 3'd1;
            w_ovf   = 1'b0;
            w_timer = '0;
          end else begin
            w_state = IDLE;
          end
        end else if (evt) begin
          w_lost = 1'b1;
        end
      end
      default: begin
        w_state = IDLE;
        w_valid = 1'b0;
      end
    endcase
  end

  assign valid    = r_valid;
  assign count    = r_count;
  assign overflow = r_ovf;
  assign lost     = r_lost;

endmodule

// File: tb/tb_press_grouper.sv
// Scoreboard bench for press_grouper (GAP=4, MAX=3): directed event
// patterns push expected groups; a monitor checks each presented group.
module tb_press_grouper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       evt = 1'b0;
  logic       ready = 1'b0;
  logic       valid;
  logic [2:0] count;
  logic       overflow;
  logic       lost;

  always #5 clk = ~clk;

  press_grouper #(
    .GAP(4),
    .MAX(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .evt(evt),
    .ready(ready),
    .valid(valid),
    .count(count),
    .overflow(overflow),
    .lost(lost)
  );

  typedef struct {
    int         rise;
    logic [2:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   t0 = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    int g;
    g = 0;
    while (cyc < c && g < 1000) begin
      tick();
      g++;
    end
  endtask

  task automatic evt_at(input int c);
    goto(c);
    evt = 1'b1;
    tick();
    evt = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_valid(input string nm);
    int g;
    g = 0;
    while (!valid && g < 60) begin
      tick();
      g++;
    end
    if (!valid) chk(nm, int'(valid), 1);
  endtask

  task automatic accept();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic push(input int rise, input int cnt, input int ovf);
    exp_t e;
    e.rise = rise;
    e.cnt  = 3'(cnt);
    e.ovf  = ovf[0];
    q.push_back(e);
  endtask

  // monitor: compare each presented group against the scoreboard
  initial begin
    logic pv;
    exp_t cur;
    pv = 1'b0;
    cur.rise = 0;
    cur.cnt = 3'd0;
    cur.ovf = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && valid && !pv) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", int'(valid), 0);
        end else begin
          cur = q.pop_front();
          chk("rise_cycle", cyc, cur.rise);
          chk("count", int'(count), int'(cur.cnt));
          chk("overflow", int'(overflow), int'(cur.ovf));
        end
      end else if (rst_n && valid && pv) begin
        chk("count_stable", int'(count), int'(cur.cnt));
        chk("ovf_stable", int'(overflow), int'(cur.ovf));
      end
      pv = rst_n && valid;
    end
  end

  initial begin
    // reset state before any clock edge
    #3;
    chk("rst_valid", int'(valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_lost", int'(lost), 0);

    // single event and handshake
    do_reset();
    push(t0 + 15, 1, 0);
    evt_at(t0 + 10);
    wait_valid("single_timeout");
    goto(t0 + 17);
    accept();
    chk("single_drop", int'(valid), 0);

    // three events in one group
    do_reset();
    push(t0 + 22, 3, 0);
    evt_at(t0 + 10);
    evt_at(t0 + 13);
    evt_at(t0 + 17);
    wait_valid("group_timeout");
    accept();

    // saturation
    do_reset();
    push(t0 + 19, 3, 1);
    for (int i = 10; i <= 14; i++) evt_at(t0 + i);
    wait_valid("sat_timeout");
    accept();

    // event on the timer==GAP-1 cycle extends the group
    do_reset();
    push(t0 + 19, 2, 0);
    evt_at(t0 + 10);
    evt_at(t0 + 14);
    wait_valid("boundary_timeout");
    accept();

    // events during HOLD
    do_reset();
    push(t0 + 15, 1, 0);
    evt_at(t0 + 10);
    wait_valid("hold_timeout");
    evt_at(t0 + 16);
    chk("hold_lost", int'(lost), 1);
    chk("hold_count", int'(count), 1);
    push(t0 + 23, 1, 0);
    goto(t0 + 18);
    evt = 1'b1;
    ready = 1'b1;
    tick();
    evt = 1'b0;
    ready = 1'b0;
    chk("hs_evt_drop", int'(valid), 0);
    wait_valid("regroup_timeout");
    accept();
    chk("lost_sticky", int'(lost), 1);

    // asynchronous reset mid-group discards the group
    t0 = cyc;
    evt_at(t0 + 10);
    goto(t0 + 12);
    rst_n = 1'b0;
    #2;
    chk("async_valid", int'(valid), 0);
    chk("async_count", int'(count), 0);
    chk("async_overflow", int'(overflow), 0);
    chk("async_lost", int'(lost), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("no_ghost_valid", int'(valid), 0);

    // event on the first edge after reset release
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    evt = 1'b1;
    t0 = cyc;
    push(t0 + 5, 1, 0);
    tick();
    evt = 1'b0;
    wait_valid("post_reset_timeout");
    accept();

    tick();
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
